inst_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32 core. It owns the program counter and issues word fetches to instruction memory over a valid/ready request channel with in-order responses. Fetched words land in a small buffer and go to the decode stage as `instruction_code` plus PC, under a valid/ready handshake. Decode includes the upper-immediate decoder. A redirect from execute flushes the buffer and discards all in-flight fetches.

---
 rtl/inst_fetch_unit_pkg.sv | 37 +++
 rtl/inst_fetch_unit_fifo.sv | 59 +++++
 rtl/inst_fetch_unit.sv | 108 ++++++++++
 tb/tb_inst_fetch_unit.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch/decode definitions for the RV32 core.
// Widths, reset PC default, opcodes and fetch buffer entry.
package inst_fetch_unit_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_ctrl_t;

  typedef struct packed {
    logic [INST_W-1:0] word;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Fetch buffer: small synchronous FIFO of {word, pc}.
// Flush empties it in one cycle and wins over push.
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= bump(wp);
      end
      if (pop) begin
        rp <= bump(rp);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rp];
  assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// RV32 instruction fetch stage: PC, imem requests, fetch buffer.
// Credits bound requests in flight plus buffered instructions.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          FETCH_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction_code,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(FETCH_DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(FETCH_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] occ;
  logic [CW-1:0] out_nxt;
  logic          req_fire;
  logic          inst_fire;
  logic          push;
  logic          empty;
  fetch_entry_t  head;
  fetch_entry_t  din;

  assign imem_req_valid = !rst &&
    (({1'b0, outstanding} + {1'b0, occ}) < CREDITS);
  assign imem_req_addr  = pc;
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign inst_valid = !empty;
  assign inst_fire = inst_valid && inst_ready;
  assign push = imem_rsp_valid && (drop == '0);
  assign out_nxt = outstanding + CW'(req_fire)
                 - CW'(imem_rsp_valid);

  assign din.word = imem_rsp_data;
  assign din.pc   = rsp_pc;

  assign instruction_code = empty ? '0 : head.word;
  assign inst_pc          = empty ? RESET_PC : head.pc;

  // fetch PC: redirect beats sequential advance
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
    end else if (req_fire) begin
      pc <= pc + 32'd4;
    end
  end

  // request/response bookkeeping and stale-response discard
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        drop <= out_nxt;
      end else if (imem_rsp_valid && drop != '0) begin
        drop <= drop - CW'(1);
      end
    end
  end

  // PC tag of the next kept response
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      rsp_pc <= word_align(redirect_pc);
    end else if (push) begin
      rsp_pc <= rsp_pc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (FETCH_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (din),
    .pop   (inst_fire),
    .head  (head),
    .count (occ),
    .empty (empty)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit.
// Memory model answers word = addr ^ 32'hA5A5_0000.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction_code;
  logic [31:0] inst_pc;

  logic        r2_valid;
  logic        r2_ready = 1'b1;
  logic [31:0] r2_addr;
  logic        rsp2_valid = 1'b0;
  logic [31:0] rsp2_data = '0;
  logic        redir2 = 1'b0;
  logic [31:0] redir2_pc = '0;
  logic        i2_valid;
  logic        i2_ready = 1'b0;
  logic [31:0] i2_code;
  logic [31:0] i2_pc;

  inst_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .instruction_code (instruction_code),
    .inst_pc          (inst_pc)
  );

  inst_fetch_unit #(
    .RESET_PC    (32'hFFFF_FFF8),
    .FETCH_DEPTH (3)
  ) dut2 (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (r2_valid),
    .imem_req_ready   (r2_ready),
    .imem_req_addr    (r2_addr),
    .imem_rsp_valid   (rsp2_valid),
    .imem_rsp_data    (rsp2_data),
    .redirect_valid   (redir2),
    .redirect_pc      (redir2_pc),
    .inst_valid       (i2_valid),
    .inst_ready       (i2_ready),
    .instruction_code (i2_code),
    .inst_pc          (i2_pc)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    int          c;
  } ev_t;

  ev_t mq[$];
  ev_t req_log[$];
  ev_t dec_log[$];
  ev_t req2_log[$];

  int   cyc = 0;
  int   lat = 1;
  logic mem_ready = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  // in-order memory with fixed latency, plus logging
  always begin
    ev_t e;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (mq.size() != 0 && mq[0].c <= cyc) begin
      e = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = e.a ^ 32'hA5A5_0000;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    imem_req_ready = mem_ready;
    @(negedge clk);
    #4;
    if (rst) begin
      mq.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{a: imem_req_addr, w: '0, c: cyc + lat});
        req_log.push_back('{a: imem_req_addr, w: '0, c: cyc});
      end
      if (inst_valid && inst_ready) begin
        dec_log.push_back('{a: inst_pc, w: instruction_code,
                            c: cyc});
      end
      if (r2_valid && r2_ready) begin
        req2_log.push_back('{a: r2_addr, w: '0, c: cyc});
      end
    end
  end

  function automatic logic [31:0] dec_a(int i);
    if (i < dec_log.size()) return dec_log[i].a;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dec_w(int i);
    if (i < dec_log.size()) return dec_log[i].w;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int dec_c(int i);
    if (i < dec_log.size()) return dec_log[i].c;
    return -1000;
  endfunction

  function automatic logic [31:0] req_a(int i);
    if (i < req_log.size()) return req_log[i].a;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int req_c(int i);
    if (i < req_log.size()) return req_log[i].c;
    return -1000;
  endfunction

  function automatic logic [31:0] req2_a(int i);
    if (i < req2_log.size()) return req2_log[i].a;
    return 32'hDEAD_BEEF;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    dec_log.delete();
    req2_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_ready = 1'b0;
    lat = 1;
    step(2);
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
    end
    n_cmp++;
    if (imem_req_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_req_addr: got %h want 0", imem_req_addr);
    end
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_inst_valid: got %b want 0", inst_valid);
    end
    n_cmp++;
    if (instruction_code !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_code: got %h want 0", instruction_code);
    end
    n_cmp++;
    if (inst_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_inst_pc: got %h want 0", inst_pc);
    end
    n_cmp++;
    if (r2_addr !== 32'hFFFF_FFF8) begin
      n_bad++;
      $display("FAIL rst2_req_addr: got %h want fffffff8", r2_addr);
    end
    n_cmp++;
    if (i2_pc !== 32'hFFFF_FFF8) begin
      n_bad++;
      $display("FAIL rst2_inst_pc: got %h want fffffff8", i2_pc);
    end
    n_cmp++;
    if (r2_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst2_req_valid: got %b want 0", r2_valid);
    end
  endtask

  task automatic test_stream();
    step(1);
    inst_ready = 1'b1;
    clear_logs();
    rst = 1'b0;
    step(12);
    n_cmp++;
    if (dec_log.size() !== 10) begin
      n_bad++;
      $display("FAIL stream_count: got %0d want 10", dec_log.size());
    end
    n_cmp++;
    if (dec_c(0) - req_c(0) !== 2) begin
      n_bad++;
      $display("FAIL stream_latency: got %0d want 2",
               dec_c(0) - req_c(0));
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dec_a(i) !== 32'(4 * i)) begin
        n_bad++;
        $display("FAIL stream_pc[%0d]: got %h want %h",
                 i, dec_a(i), 32'(4 * i));
      end
      n_cmp++;
      if (dec_w(i) !== (32'(4 * i) ^ 32'hA5A5_0000)) begin
        n_bad++;
        $display("FAIL stream_word[%0d]: got %h want %h",
                 i, dec_w(i), 32'(4 * i) ^ 32'hA5A5_0000);
      end
      if (i > 0) begin
        n_cmp++;
        if (dec_c(i) !== dec_c(i - 1) + 1) begin
          n_bad++;
          $display("FAIL stream_b2b[%0d]: got cyc %0d want %0d",
                   i, dec_c(i), dec_c(i - 1) + 1);
        end
      end
    end
  endtask

  task automatic test_stall();
    int bad;
    rst = 1'b1;
    inst_ready = 1'b0;
    lat = 1;
    step(2);
    clear_logs();
    rst = 1'b0;
    step(2);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(inst_valid === 1'b1 && inst_pc === 32'h0 &&
            instruction_code === 32'hA5A5_0000)) bad++;
      step(1);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL stall_hold: got %0d unstable cycles want 0", bad);
    end
    n_cmp++;
    if (req_log.size() !== 3) begin
      n_bad++;
      $display("FAIL stall_reqs: got %0d want 3", req_log.size());
    end
    n_cmp++;
    if (req_a(2) !== 32'h8) begin
      n_bad++;
      $display("FAIL stall_req2: got %h want 8", req_a(2));
    end
    clear_logs();
    inst_ready = 1'b1;
    step(6);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dec_a(i) !== 32'(4 * i)) begin
        n_bad++;
        $display("FAIL drain_pc[%0d]: got %h want %h",
                 i, dec_a(i), 32'(4 * i));
      end
    end
    n_cmp++;
    if (req_a(0) !== 32'hC) begin
      n_bad++;
      $display("FAIL resume_addr: got %h want c", req_a(0));
    end
  endtask

  task automatic test_redirect();
    rst = 1'b1;
    inst_ready = 1'b1;
    lat = 3;
    step(2);
    clear_logs();
    rst = 1'b0;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step(1);
    redirect_valid = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_valid_n1: got %b want 0", inst_valid);
    end
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL redir_req_n1: got %b/%h want 1/00000100",
               imem_req_valid, imem_req_addr);
    end
    step(15);
    n_cmp++;
    if (req_a(1) !== 32'h4 || req_a(2) !== 32'h100) begin
      n_bad++;
      $display("FAIL redir_req_seq: got %h,%h want 4,100",
               req_a(1), req_a(2));
    end
    n_cmp++;
    if (req_c(2) - req_c(1) !== 1) begin
      n_bad++;
      $display("FAIL redir_req_gap: got %0d want 1",
               req_c(2) - req_c(1));
    end
    n_cmp++;
    if (dec_a(0) !== 32'h100) begin
      n_bad++;
      $display("FAIL redir_first_pc: got %h want 100", dec_a(0));
    end
    n_cmp++;
    if (dec_w(0) !== 32'hA5A5_0100) begin
      n_bad++;
      $display("FAIL redir_first_word: got %h want a5a50100", dec_w(0));
    end
    n_cmp++;
    if (dec_a(1) !== 32'h104) begin
      n_bad++;
      $display("FAIL redir_second_pc: got %h want 104", dec_a(1));
    end
    n_cmp++;
    if (dut.drop !== '0) begin
      n_bad++;
      $display("FAIL redir_drop: got %0d want 0", dut.drop);
    end
  endtask

  task automatic test_collision();
    int old;
    rst = 1'b1;
    inst_ready = 1'b1;
    lat = 1;
    step(2);
    clear_logs();
    rst = 1'b0;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
      n_bad++;
      $display("FAIL coll_req: got %b/%h want 1/00000004",
               imem_req_valid, imem_req_addr);
    end
    step(1);
    redirect_valid = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL coll_valid: got %b want 0", inst_valid);
    end
    n_cmp++;
    if (dut.drop !== 2'd1) begin
      n_bad++;
      $display("FAIL coll_drop_mid: got %0d want 1", dut.drop);
    end
    step(10);
    old = 0;
    foreach (dec_log[i]) begin
      if (dec_log[i].a < 32'h200) old++;
    end
    n_cmp++;
    if (old !== 0) begin
      n_bad++;
      $display("FAIL coll_stale: got %0d stale instrs want 0", old);
    end
    n_cmp++;
    if (dec_a(0) !== 32'h200 || dec_w(0) !== 32'hA5A5_0200) begin
      n_bad++;
      $display("FAIL coll_first: got %h/%h want 00000200/a5a50200",
               dec_a(0), dec_w(0));
    end
    n_cmp++;
    if (dut.drop !== '0) begin
      n_bad++;
      $display("FAIL coll_drop_end: got %0d want 0", dut.drop);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    inst_ready = 1'b0;
    lat = 1;
    step(2);
    rst = 1'b0;
    step(8);
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_full: got %b/%b want 1/0",
               inst_valid, imem_req_valid);
    end
    step(1);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_inst_valid: got %b want 0", inst_valid);
    end
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_req_valid: got %b want 0", imem_req_valid);
    end
    step(1);
    clear_logs();
    inst_ready = 1'b1;
    rst = 1'b0;
    step(6);
    n_cmp++;
    if (req_a(0) !== 32'h0 || req_a(1) !== 32'h4) begin
      n_bad++;
      $display("FAIL mid_restart: got %h,%h want 0,4",
               req_a(0), req_a(1));
    end
    n_cmp++;
    if (dec_a(0) !== 32'h0 || dec_w(0) !== 32'hA5A5_0000) begin
      n_bad++;
      $display("FAIL mid_first: got %h/%h want 0/a5a50000",
               dec_a(0), dec_w(0));
    end
  endtask

  task automatic test_reset_pc();
    rst = 1'b1;
    step(2);
    clear_logs();
    rst = 1'b0;
    step(6);
    n_cmp++;
    if (req2_log.size() !== 3) begin
      n_bad++;
      $display("FAIL rpc_count: got %0d want 3", req2_log.size());
    end
    n_cmp++;
    if (req2_a(0) !== 32'hFFFF_FFF8) begin
      n_bad++;
      $display("FAIL rpc_a0: got %h want fffffff8", req2_a(0));
    end
    n_cmp++;
    if (req2_a(1) !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL rpc_a1: got %h want fffffffc", req2_a(1));
    end
    n_cmp++;
    if (req2_a(2) !== 32'h0) begin
      n_bad++;
      $display("FAIL rpc_a2: got %h want 0", req2_a(2));
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_collision();
    test_reset_mid();
    test_reset_pc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
